// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared display-geometry constants for the game matrix:
//                display timing origin, cell pitch/offset, grid size and
//                index/position widths. Used by the index mapper, the sprite
//                renderer and the game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Display timing: first visible pixel / line
    localparam int unsigned H_VIS_START = 336;
    localparam int unsigned V_VIS_START = 27;

    // Cell geometry (same on both axes)
    localparam int unsigned CELL_PX     = 16;
    localparam int unsigned CELL_OFS    = 7;
    localparam int unsigned CELL_SHIFT  = $clog2(CELL_PX);

    // Game grid size
    localparam int unsigned GRID_COLS   = 80;
    localparam int unsigned GRID_ROWS   = 45;

    // Index and position widths
    localparam int unsigned IDX_X_W     = 7;
    localparam int unsigned IDX_Y_W     = 6;
    localparam int unsigned POS_X_W     = 11;
    localparam int unsigned POS_Y_W     = 10;

    // Largest coordinate an in-range index can produce on each axis
    localparam int unsigned MAX_POS_X   = H_VIS_START + CELL_OFS + (GRID_COLS - 1) * CELL_PX;
    localparam int unsigned MAX_POS_Y   = V_VIS_START + CELL_OFS + (GRID_ROWS - 1) * CELL_PX;

    // True when v is a non-zero power of two
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/axis_index_to_pixel.sv
`default_nettype none
// ============================================================================
//  Module      : axis_index_to_pixel
//  Description : Combinational single-axis mapping of a cell index to its
//                sprite draw coordinate: pos = BASE + OFFSET + (idx << SHIFT).
//                The sum is formed one bit wider than the output and then
//                truncated. Also reports whether the index is below COUNT.
//  Ports       : idx_i      - cell index on this axis
//                pos_o      - pixel coordinate (truncated to POS_W)
//                in_range_o - idx_i < COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_index_to_pixel #(
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned POS_W  = 11,
    parameter int unsigned BASE   = 336,
    parameter int unsigned OFFSET = 7,
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned COUNT  = 80
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [POS_W-1:0] pos_o,
    output logic             in_range_o
);

    localparam int unsigned         C_FULL_W = POS_W + 1;
    localparam logic [C_FULL_W-1:0] C_ORIGIN = C_FULL_W'(BASE + OFFSET);
    localparam logic [IDX_W:0]      C_COUNT  = (IDX_W + 1)'(COUNT);

    logic [C_FULL_W-1:0] w_idx_ext;
    logic [C_FULL_W-1:0] w_full;
    logic                w_unused_msb;

    // Shift replaces the multiply; pitch is a power of two.
    assign w_idx_ext    = C_FULL_W'(idx_i);
    assign w_full       = C_ORIGIN + (w_idx_ext << SHIFT);
    assign pos_o        = w_full[POS_W-1:0];
    // Only reachable by out-of-range indices, whose position is discarded.
    assign w_unused_msb = w_full[POS_W];

    assign in_range_o   = ({1'b0, idx_i} < C_COUNT);

endmodule : axis_index_to_pixel
`default_nettype wire

// File: rtl/map_index_to_display.sv
`default_nettype none
// ============================================================================
//  Module      : map_index_to_display
//  Description : Maps a game-matrix cell index (x,y) to the display pixel at
//                which the cell sprite is drawn. One register stage; indices
//                outside the grid raise out_of_range for one cycle and leave
//                the last good position in place.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                matrix_idx_x/_y      - cell column / row index
//                idx_valid            - qualifies the indices this cycle
//                display_pos_x/_y     - registered pixel coordinate
//                pos_valid            - one-cycle pulse per in-range index
//                out_of_range         - one-cycle pulse per out-of-range index
//  Revision    : 1.0 - initial release
// ============================================================================
module map_index_to_display
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_X_W-1:0] matrix_idx_x,
    input  logic [IDX_Y_W-1:0] matrix_idx_y,
    input  logic               idx_valid,
    output logic [POS_X_W-1:0] display_pos_x,
    output logic [POS_Y_W-1:0] display_pos_y,
    output logic               pos_valid,
    output logic               out_of_range
);

    // ------------------------------------------------------------------
    // Elaboration-time geometry checks
    // ------------------------------------------------------------------
    if (!is_pow2(CELL_PX)) begin : g_chk_cell_pow2
        $error("map_index_to_display: CELL_PX must be a power of two");
    end
    if (MAX_POS_X >= (1 << POS_X_W)) begin : g_chk_max_x
        $error("map_index_to_display: max in-range x does not fit POS_X_W");
    end
    if (MAX_POS_Y >= (1 << POS_Y_W)) begin : g_chk_max_y
        $error("map_index_to_display: max in-range y does not fit POS_Y_W");
    end

    // ------------------------------------------------------------------
    // Per-axis combinational mapping
    // ------------------------------------------------------------------
    logic [POS_X_W-1:0] w_pos_x;
    logic [POS_Y_W-1:0] w_pos_y;
    logic               w_x_in_range;
    logic               w_y_in_range;
    logic               w_in_range;

    axis_index_to_pixel #(
        .IDX_W  (IDX_X_W),
        .POS_W  (POS_X_W),
        .BASE   (H_VIS_START),
        .OFFSET (CELL_OFS),
        .SHIFT  (CELL_SHIFT),
        .COUNT  (GRID_COLS)
    ) u_axis_x (
        .idx_i      (matrix_idx_x),
        .pos_o      (w_pos_x),
        .in_range_o (w_x_in_range)
    );

    axis_index_to_pixel #(
        .IDX_W  (IDX_Y_W),
        .POS_W  (POS_Y_W),
        .BASE   (V_VIS_START),
        .OFFSET (CELL_OFS),
        .SHIFT  (CELL_SHIFT),
        .COUNT  (GRID_ROWS)
    ) u_axis_y (
        .idx_i      (matrix_idx_y),
        .pos_o      (w_pos_y),
        .in_range_o (w_y_in_range)
    );

    assign w_in_range = w_x_in_range & w_y_in_range;

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [POS_X_W-1:0] pos_x_q, pos_x_d;
    logic [POS_Y_W-1:0] pos_y_q, pos_y_d;
    logic               pos_valid_q, pos_valid_d;
    logic               oor_q, oor_d;

    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        pos_valid_d = 1'b0;
        oor_d       = 1'b0;
        if (idx_valid) begin
            if (w_in_range) begin
                pos_x_d     = w_pos_x;
                pos_y_d     = w_pos_y;
                pos_valid_d = 1'b1;
            end else begin
                // Keep the last good position so the renderer never sees
                // a coordinate derived from an illegal index.
                oor_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pos_valid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            pos_valid_q <= pos_valid_d;
            oor_q       <= oor_d;
        end
    end

    assign display_pos_x = pos_x_q;
    assign display_pos_y = pos_y_q;
    assign pos_valid     = pos_valid_q;
    assign out_of_range  = oor_q;

endmodule : map_index_to_display
`default_nettype wire

// File: tb/tb_map_index_to_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_map_index_to_display
//  Description : Scoreboard bench for map_index_to_display. Directed vectors
//                push their hand-computed expected outputs, tagged with the
//                cycle they are due; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_map_index_to_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  matrix_idx_x;
    logic [5:0]  matrix_idx_y;
    logic        idx_valid;
    logic [10:0] display_pos_x;
    logic [9:0]  display_pos_y;
    logic        pos_valid;
    logic        out_of_range;

    map_index_to_display u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .matrix_idx_x  (matrix_idx_x),
        .matrix_idx_y  (matrix_idx_y),
        .idx_valid     (idx_valid),
        .display_pos_x (display_pos_x),
        .display_pos_y (display_pos_y),
        .pos_valid     (pos_valid),
        .out_of_range  (out_of_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
        int pv;
        int oor;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare every result that falls due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("pos_x",        int'(display_pos_x), e.x);
            chk("pos_y",        int'(display_pos_y), e.y);
            chk("pos_valid",    int'(pos_valid),     e.pv);
            chk("out_of_range", int'(out_of_range),  e.oor);
        end
    end

    // Drive one input cycle and queue the response expected one cycle later.
    task automatic drive(input int x, input int y, input int v,
                         input int ex, input int ey, input int epv, input int eoor);
        exp_t e;
        @(negedge clk);
        matrix_idx_x = 7'(x);
        matrix_idx_y = 6'(y);
        idx_valid    = v[0];
        e.due = cyc + 1;
        e.x   = ex;
        e.y   = ey;
        e.pv  = epv;
        e.oor = eoor;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        matrix_idx_x = 7'd5;
        matrix_idx_y = 6'd5;
        idx_valid    = 1'b1;

        // 1. Held in reset with a valid index present: outputs stay cleared.
        repeat (3) @(negedge clk);
        chk("rst_pos_x",     int'(display_pos_x), 0);
        chk("rst_pos_y",     int'(display_pos_y), 0);
        chk("rst_pos_valid", int'(pos_valid),     0);
        chk("rst_oor",       int'(out_of_range),  0);
        // Release with (5,5) still valid: first edge yields (423,114).
        drive(5, 5, 1, 423, 114, 1, 0);
        rst_n = 1'b1;

        // 2. Origin cell
        drive(0, 0, 1, 343, 34, 1, 0);
        // 3. Back-to-back valid indices
        drive(7, 7, 1, 455, 146, 1, 0);
        drive(9, 5, 1, 487, 114, 1, 0);
        // 4. Last in-range cell, then out-of-range on each axis
        drive(79, 44, 1, 1607, 738, 1, 0);
        drive(80, 0,  1, 1607, 738, 0, 1);
        drive(0,  45, 1, 1607, 738, 0, 1);
        drive(127, 63, 1, 1607, 738, 0, 1);
        drive(79, 0,  1, 1607, 34,  1, 0);
        // 5. Unqualified index holds; then the same index qualified
        drive(3, 2, 0, 1607, 34, 0, 0);
        drive(3, 2, 1, 391,  66, 1, 0);
        drive(3, 2, 0, 391,  66, 0, 0);

        // 6. Reset between two valid inputs
        drive(1, 1, 1, 359, 50, 1, 0);
        @(negedge clk);
        matrix_idx_x = 7'd2;
        matrix_idx_y = 6'd2;
        idx_valid    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pos_x",     int'(display_pos_x), 0);
        chk("async_pos_y",     int'(display_pos_y), 0);
        chk("async_pos_valid", int'(pos_valid),     0);
        chk("async_oor",       int'(out_of_range),  0);
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(4, 1, 1, 407, 50, 1, 0);
        drive(0, 0, 0, 407, 50, 0, 0);

        // Let the scoreboard drain, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_map_index_to_display
`default_nettype wire
